// File: rtl/mul_seq_ctrl.sv
// Sequencer for the nibble-multiply step block; STEP_TIMEOUT_EN adds a RUN-cycle abort (TIMEOUT_CYC).
// Latency: result valid at the edge ending the step block's done cycle, N = step path length (3..5).
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready, no same-cycle turnaround.
module mul_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  op_x,
    input  logic [7:0]  op_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  prod,
    output logic        err,
    output logic [15:0] step_p1,
    output logic [7:0]  step_p2,
    output logic [2:0]  step_state_in,
    input  logic [2:0]  step_state_out,
    input  logic [7:0]  step_n1,
    input  logic [7:0]  step_n2,
    input  logic        step_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] st_q, st_d;
    logic [7:0] prod_q, prod_d;

`ifdef STEP_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYC - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            st_q   <= '0;
            prod_q <= '0;
`ifdef STEP_TIMEOUT_EN
            cnt_q  <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
            st_q   <= st_d;
            prod_q <= prod_d;
`ifdef STEP_TIMEOUT_EN
            cnt_q  <= cnt_d;
            err_q  <= err_d;
`endif
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        x_d    = x_q;
        y_d    = y_q;
        acc_d  = acc_q;
        st_d   = st_q;
        prod_d = prod_q;
`ifdef STEP_TIMEOUT_EN
        cnt_d  = cnt_q;
        err_d  = err_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    x_d   = op_x;
                    y_d   = op_y;
                    st_d  = 3'b000;
                    acc_d = '0;
                    fsm_d = RUN;
`ifdef STEP_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            RUN: begin
                if (step_done) begin
                    // The step block owns the arithmetic; its n1 in the done cycle is the answer.
                    prod_d = step_n1;
                    st_d   = 3'b000;
                    fsm_d  = HOLD;
`ifdef STEP_TIMEOUT_EN
                    err_d  = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    prod_d = 8'h00;
                    err_d  = 1'b1;
                    st_d   = 3'b000;
                    fsm_d  = HOLD;
`endif
                end else begin
                    st_d  = step_state_out;
                    acc_d = step_n2;
`ifdef STEP_TIMEOUT_EN
                    cnt_d = cnt_q + 4'd1;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready      = (fsm_q == IDLE);
    assign out_valid     = (fsm_q == HOLD);
    assign prod          = prod_q;
    assign step_p1       = {x_q, y_q};
    assign step_p2       = acc_q;
    assign step_state_in = st_q;

`ifdef STEP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural nibble-multiply step block.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op_x;
    logic [7:0]  op_y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  prod;
    logic        err;
    logic [15:0] step_p1;
    logic [7:0]  step_p2;
    logic [2:0]  step_state_in;
    logic [2:0]  step_state_out;
    logic [7:0]  step_n1;
    logic [7:0]  step_n2;
    logic        step_done;
    logic        force_nodone;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(.TIMEOUT_CYC(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_x           (op_x),
        .op_y           (op_y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .prod           (prod),
        .err            (err),
        .step_p1        (step_p1),
        .step_p2        (step_p2),
        .step_state_in  (step_state_in),
        .step_state_out (step_state_out),
        .step_n1        (step_n1),
        .step_n2        (step_n2),
        .step_done      (step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step block model: x = {xh,xl}, y = {yh,yl}; accumulates the low byte of x*y.
    logic [3:0] xh, xl, yh, yl;
    logic [7:0] p_hl, p_lh;
    assign xh   = step_p1[15:12];
    assign xl   = step_p1[11:8];
    assign yh   = step_p1[7:4];
    assign yl   = step_p1[3:0];
    assign p_hl = {4'b0, xh} * {4'b0, yl};
    assign p_lh = {4'b0, xl} * {4'b0, yh};
    assign step_n1 = step_p2;

    always_comb begin
        step_state_out = 3'b111;
        step_n2        = step_p2;
        step_done      = 1'b0;
        case (step_state_in)
            3'b000: begin
                step_n2        = {4'b0, xl} * {4'b0, yl};
                step_state_out = (xl == 4'd0) ? 3'b001 : 3'b010;
            end
            3'b001: step_state_out = 3'b111;
            3'b010: begin
                if (xh == 4'd0) begin
                    step_state_out = 3'b011;
                end else begin
                    step_n2        = step_p2 + (p_hl << 4);
                    step_state_out = 3'b100;
                end
            end
            3'b011: begin
                step_n2        = step_p2 + (p_lh << 4);
                step_state_out = 3'b111;
            end
            3'b100: begin
                step_n2        = step_p2 + (p_lh << 4);
                step_state_out = (yh == 4'd0) ? 3'b111 : 3'b110;
            end
            3'b110: step_state_out = 3'b111;
            3'b111: step_done = ~force_nodone;
            default: step_state_out = 3'b111;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One operation with out_ready=1; sts/accs list expected st_q/acc_q per RUN cycle, MSB first.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int n,
                          input logic [14:0] sts, input logic [39:0] accs,
                          input logic [7:0] exp_prod);
        in_valid  = 1'b1;
        op_x      = x;
        op_y      = y;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("run_p1", 32'(step_p1), 32'({x, y}));
        check("run_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            check($sformatf("run_state[%0d]", i), 32'(step_state_in), 32'(sts[14-3*i -: 3]));
            check($sformatf("run_acc[%0d]", i), 32'(step_p2), 32'(accs[39-8*i -: 8]));
            check($sformatf("run_out_valid[%0d]", i), 32'(out_valid), 32'd0);
            tick();
        end
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_prod", 32'(prod), 32'(exp_prod));
        check("done_err", 32'(err), 32'd0);
        check("hold_state", 32'(step_state_in), 32'd0);
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] sx, sy, sexp;
        bit         got;
        int         hs;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        op_x         = 8'h00;
        op_y         = 8'h00;
        out_ready    = 1'b0;
        force_nodone = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_state", 32'(step_state_in), 32'd0);
        check("rst_acc", 32'(step_p2), 32'd0);
        check("rst_p1", 32'(step_p1), 32'd0);
        rst_n = 1'b1;
        tick();

        // Five-step path: 0x23*0x45 = 0x96F
        run_op(8'h23, 8'h45, 5, {3'd0, 3'd2, 3'd4, 3'd6, 3'd7},
               {8'h00, 8'h0F, 8'hAF, 8'h6F, 8'h6F}, 8'h6F);

        // Four-step path with zero high nibble: 0x03*0x45 = 0xCF
        run_op(8'h03, 8'h45, 4, {3'd0, 3'd2, 3'd3, 3'd7, 3'd0},
               {8'h00, 8'h0F, 8'h0F, 8'hCF, 8'h00}, 8'hCF);

        // Backpressure with a new operand pair already waiting
        in_valid  = 1'b1;
        op_x      = 8'h23;
        op_y      = 8'h45;
        out_ready = 1'b0;
        tick();
        op_x = 8'h03;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_out_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_prod[%0d]", i), 32'(prod), 32'h6F);
            check($sformatf("bp_in_ready[%0d]", i), 32'(in_ready), 32'd0);
            if (i < 5) tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        check("bp_next_p1", 32'(step_p1), 32'h0345);
        for (int i = 0; i < 4; i++) tick();
        check("bp_next_out_valid", 32'(out_valid), 32'd1);
        check("bp_next_prod", 32'(prod), 32'hCF);
        tick();

        // Reset in the second RUN cycle discards the operation
        in_valid = 1'b1;
        op_x     = 8'h23;
        op_y     = 8'h45;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_state", 32'(step_state_in), 32'd0);
        check("mid_rst_acc", 32'(step_p2), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_rst_out_valid[%0d]", i), 32'(out_valid), 32'd0);
        end
        run_op(8'h03, 8'h45, 4, {3'd0, 3'd2, 3'd3, 3'd7, 3'd0},
               {8'h00, 8'h0F, 8'h0F, 8'hCF, 8'h00}, 8'hCF);

        // Stream of random operands with random consumer stalls
        hs = 0;
        for (int k = 0; k < 20; k++) begin
            sx   = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 15))};
            sy   = 8'($urandom_range(0, 255));
            sexp = 8'(sx * sy);
            check($sformatf("str_in_ready[%0d]", k), 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            op_x      = sx;
            op_y      = sy;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check($sformatf("str_prod[%0d]", k), 32'(prod), 32'(sexp));
                    got = 1'b1;
                    hs++;
                end
                tick();
            end
            check($sformatf("str_completed[%0d]", k), 32'(got), 32'd1);
            check($sformatf("str_no_dup[%0d]", k), 32'(out_valid), 32'd0);
        end
        check("str_handshakes", 32'(hs), 32'd20);
        out_ready = 1'b0;

        // Step block never signals done
        force_nodone = 1'b1;
        in_valid     = 1'b1;
        op_x         = 8'h23;
        op_y         = 8'h45;
        tick();
        in_valid = 1'b0;
`ifdef STEP_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tmo_out_valid[%0d]", i), 32'(out_valid), 32'd0);
            tick();
        end
        check("tmo_out_valid", 32'(out_valid), 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_prod", 32'(prod), 32'h00);
        force_nodone = 1'b0;
        out_ready    = 1'b1;
        tick();
        check("tmo_idle", 32'(in_ready), 32'd1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("notmo_out_valid", 32'(out_valid), 32'd0);
        check("notmo_err", 32'(err), 32'd0);
        check("notmo_in_ready", 32'(in_ready), 32'd0);
        force_nodone = 1'b0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif
        run_op(8'h23, 8'h45, 5, {3'd0, 3'd2, 3'd4, 3'd6, 3'd7},
               {8'h00, 8'h0F, 8'hAF, 8'h6F, 8'h6F}, 8'h6F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential driver for the combinational nibble-multiply step block (mul).
- Accepts an 8-bit operand pair over a valid/ready handshake.
- Holds the step state register and the partial-product accumulator.
- Iterates the step block until it signals done, then presents the 8-bit result over a valid/ready output handshake.

Parameters:
- TIMEOUT_CYC, 8, maximum RUN cycles before abort (used only with STEP_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- op_x  input  8  operand X; drives step pclP1[15:8]
- op_y  input  8  operand Y; drives step pclP1[7:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- prod  output  8  result byte
- err  output  1  result aborted by timeout (0 without macro)
- step_p1  output  16  to step pclP1, equals {x_q, y_q}
- step_p2  output  8  to step pclP2, equals acc_q
- step_state_in  output  3  to step stateIn, equals st_q
- step_state_out  input  3  from step stateOut
- step_n1  input  8  from step pclN1
- step_n2  input  8  from step pclN2
- step_done  input  1  from step done

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all registers clear asynchronously while rst_n=0.
  - fsm=IDLE; x_q, y_q, acc_q, st_q, prod = 0.
  - out_valid=0, err=0, in_ready=1.
- Reset mid-operation discards the operation. No output is produced for it.
- Controller FSM has three states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1: x_q<=op_x, y_q<=op_y, st_q<=3'b000, acc_q<=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle with step_done=0: st_q<=step_state_out, acc_q<=step_n2.
  - Cycle with step_done=1: prod<=step_n1, out_valid<=1, err<=0, st_q<=3'b000, go to HOLD.
- HOLD:
  - out_valid=1; prod and err are stable.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - New operands are accepted no earlier than the cycle after the handshake (no same-cycle turnaround).
- Latency: from the accepting edge, RUN lasts N cycles, where N = step path length.
  - 3 cycles: path 000,001,111.
  - 4 cycles: paths 000,010,011,111 and 000,010,100,111.
  - 5 cycles: path 000,010,100,110,111.
  - out_valid rises at the edge ending the done cycle.
- Result value is exactly step_n1 in the done cycle. The controller performs no arithmetic.
- Unused step state codes (101) are passed through. The step block maps them to 111, which is then handled as a normal done.
- step_* outputs are driven in every FSM state.
  - Outside RUN, st_q=000 and acc_q holds its last value. The step outputs are then ignored.
- in_valid held across HOLD is not accepted until IDLE.

Optional Feature:
- Macro: STEP_TIMEOUT_EN.
- Defined:
  - A 4-bit RUN cycle counter clears on entry to RUN and increments each RUN cycle.
  - If the counter reaches TIMEOUT_CYC with step_done still 0: prod<=8'h00, err<=1, out_valid<=1, go to HOLD.
  - Counter clears on reset.
- Undefined: no counter; err is tied 0; RUN waits indefinitely for step_done.

Test Plan:
- Reset during RUN:
  - Stimulus: x=0x23, y=0x45; rst_n low in the 2nd RUN cycle.
  - Response: out_valid stays 0, in_ready=1 immediately, st_q=0, acc_q=0.
  - After release, a new operation completes normally.
- Five-step path:
  - Stimulus: x=0x23, y=0x45, out_ready=1.
  - Response: step_state_in sequence 000,010,100,110,111; step_p2 sequence 00,0F,AF,6F,6F.
  - prod=0x6F with out_valid one cycle after the done cycle; err=0.
- Four-step path (b=0):
  - Stimulus: x=0x03, y=0x45.
  - Response: states 000,010,011,111; prod=0xCF after 4 RUN cycles.
- Backpressure:
  - Stimulus: x=0x23, y=0x45, out_ready=0 for 6 cycles after out_valid, in_valid held 1 with x=0x03.
  - Response: prod stays 0x6F, in_ready=0 throughout HOLD.
  - After out_ready=1, return to IDLE; the next op is accepted the following cycle and yields 0xCF.
- Back-to-back stream:
  - Stimulus: 20 random operand pairs with a≠0; out_ready randomly toggled.
  - Response: every prod equals a step-block model result, in order, with no drops or duplicates.
- Timeout (STEP_TIMEOUT_EN):
  - Stimulus: force step_done=0 with TIMEOUT_CYC=8.
  - Response: after 8 RUN cycles, out_valid=1, err=1, prod=0x00.
  - Without the macro: out_valid stays 0 and err=0.
